// File: rtl/i2s_transmitter_if.sv
// Sample handshake between the upstream effects chain (master) and the I2S transmitter (slave).
interface i2s_transmitter_if;
  logic signed [15:0] leftSampleIn;
  logic signed [15:0] rightSampleIn;
  logic               sampleValid;
  logic               sampleReady;

  modport master (output leftSampleIn, output rightSampleIn, output sampleValid, input sampleReady);
  modport slave  (input leftSampleIn, input rightSampleIn, input sampleValid, output sampleReady);
endinterface

// File: rtl/i2s_transmitter.sv
// I2S transmitter: one-deep stereo holding register serialized into 64-BCLK frames.
// Build option I2S_TX_MUTE_ON_UNDERRUN_EN: underrun frames send silence instead of repeating the last pair.
module i2s_transmitter #(
  parameter int BCLK_DIV = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  i2s_transmitter_if.slave smp,
  output logic             BCLK,
  output logic             LRCLK,
  output logic             SDATA,
  output logic             underrun
);

  if (BCLK_DIV < 2 || BCLK_DIV > 255) begin : g_div_check
    $error("BCLK_DIV must be in 2..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        bclk_q, bclk_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        lrclk_q, lrclk_d;
  logic        sdata_q, sdata_d;
  logic        underrun_q, underrun_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;
  logic [15:0] shift_l_q, shift_l_d;
  logic [15:0] shift_r_q, shift_r_d;

  logic        div_wrap;
  logic        fall_evt;
  logic        frame_load;
  logic        accept;
  logic        in_word;
  logic [4:0]  slot;
  logic [3:0]  bit_idx;
  logic [15:0] word;

  always_comb begin
    div_wrap   = (div_cnt_q == DIV_LAST);
    div_cnt_d  = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
    bclk_d     = div_wrap ? ~bclk_q : bclk_q;
    fall_evt   = div_wrap && bclk_q;
    bit_cnt_d  = fall_evt ? bit_cnt_q + 6'd1 : bit_cnt_q;
    frame_load = fall_evt && (bit_cnt_q == 6'd63);
    accept     = smp.sampleValid && !hold_full_q;

    // A load in the same cycle as an accept still sees the old holding state.
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_l_d    = smp.leftSampleIn;
      hold_r_d    = smp.rightSampleIn;
      hold_full_d = 1'b1;
    end else if (frame_load) begin
      hold_full_d = 1'b0;
    end

    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    if (frame_load) begin
      if (hold_full_q) begin
        shift_l_d = hold_l_q;
        shift_r_d = hold_r_q;
      end
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
      else begin
        shift_l_d = '0;
        shift_r_d = '0;
      end
`endif
    end
    underrun_d = frame_load && !hold_full_q;

    // Slots 1..16 of each half-frame carry the word MSB first, one BCLK behind LRCLK.
    slot    = bit_cnt_d[4:0];
    in_word = (slot != 5'd0) && (slot <= 5'd16);
    bit_idx = 4'(5'd16 - slot);
    word    = bit_cnt_d[5] ? shift_r_q : shift_l_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    if (fall_evt) begin
      lrclk_d = bit_cnt_d[5];
      sdata_d = in_word && word[bit_idx];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= 6'd63;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
    end
  end

  assign smp.sampleReady = !hold_full_q;
  assign BCLK            = bclk_q;
  assign LRCLK           = lrclk_q;
  assign SDATA           = sdata_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: cycle-level model of BCLK/LRCLK/SDATA/underrun with a queue of accepted pairs.
`timescale 1ns/1ps
module tb_i2s_transmitter;

  localparam int DIV   = 2;
  localparam int HALF  = 5;
  localparam int FRAME = 128 * DIV;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    time         t;
  } acc_t;

  logic CLK  = 1'b0;
  logic nRST = 1'b1;
  logic BCLK, LRCLK, SDATA, underrun;

  i2s_transmitter_if smp();

  i2s_transmitter #(.BCLK_DIV(DIV)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .smp      (smp),
    .BCLK     (BCLK),
    .LRCLK    (LRCLK),
    .SDATA    (SDATA),
    .underrun (underrun)
  );

  always #HALF CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  bit          mon_en = 1'b0;
  acc_t        acc_q[$];
  logic [15:0] cur_l = '0;
  logic [15:0] cur_r = '0;
  logic [15:0] rx_l = '0;
  logic [15:0] rx_r = '0;
  int          m_falls, m_b;
  bit          m_fall, m_uflow, m_ready;
  logic        m_sd, m_lr;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Posedges since reset release; the whole output model is derived from this count.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) k <= 0;
    else       k <= k + 1;
  end

  always @(negedge CLK) begin
    if (nRST && mon_en) begin
      m_falls = k / (2 * DIV);
      m_fall  = (k > 0) && (k % (2 * DIV) == 0);
      m_b     = (63 + m_falls) % 64;
      m_uflow = 1'b0;
      if (m_fall && m_b == 0) begin
        if (acc_q.size() > 0 && acc_q[0].t < $time - HALF) begin
          cur_l = acc_q[0].l;
          cur_r = acc_q[0].r;
          void'(acc_q.pop_front());
        end else begin
          m_uflow = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          cur_l = '0;
          cur_r = '0;
`endif
        end
        rx_l = '0;
        rx_r = '0;
      end
      m_ready = !(acc_q.size() > 0 && acc_q[0].t < $time);
      m_lr    = (m_falls > 0) && (m_b >= 32);
      if (m_b >= 1 && m_b <= 16)       m_sd = cur_l[16 - m_b];
      else if (m_b >= 33 && m_b <= 48) m_sd = cur_r[48 - m_b];
      else                             m_sd = 1'b0;

      check_output("bclk", BCLK, ((k / DIV) % 2));
      check_output("lrclk", LRCLK, m_lr);
      check_output("sdata", SDATA, m_sd);
      check_output("underrun", underrun, m_uflow);
      check_output("sample_ready", smp.sampleReady, m_ready);

      if (m_fall && m_b >= 1 && m_b <= 16)  rx_l = {rx_l[14:0], SDATA};
      if (m_fall && m_b >= 33 && m_b <= 48) rx_r = {rx_r[14:0], SDATA};
      if (m_fall && m_b == 48) begin
        check_output("frame_left", rx_l, cur_l);
        check_output("frame_right", rx_r, cur_r);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check_output({tag, "_bclk"}, BCLK, 0);
    check_output({tag, "_lrclk"}, LRCLK, 0);
    check_output({tag, "_sdata"}, SDATA, 0);
    check_output({tag, "_ready"}, smp.sampleReady, 1);
    check_output({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic reset_dut(input string tag);
    mon_en = 1'b0;
    nRST   = 1'b0;
    acc_q.delete();
    cur_l = '0;
    cur_r = '0;
    #1;
    check_reset_values({tag, "_async"});
    repeat (3) @(negedge CLK);
    check_reset_values({tag, "_held"});
    nRST   = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [15:0] l, input logic [15:0] r,
                                input logic [15:0] exp_l, input logic [15:0] exp_r);
    int   n;
    acc_t a;
    n = 0;
    @(negedge CLK);
    while (!smp.sampleReady && n < 4 * FRAME) begin
      @(negedge CLK);
      n++;
    end
    if (!smp.sampleReady) begin
      check_output("ready_timeout", 0, 1);
    end else begin
      smp.leftSampleIn  = l;
      smp.rightSampleIn = r;
      smp.sampleValid   = 1'b1;
      a.l = exp_l;
      a.r = exp_r;
      a.t = $time + HALF;
      acc_q.push_back(a);
      @(negedge CLK);
      smp.sampleValid = 1'b0;
    end
  endtask

  task automatic wait_k(input int target);
    int n;
    n = 0;
    @(negedge CLK);
    while (k != target && n < 4 * FRAME) begin
      @(negedge CLK);
      n++;
    end
    if (k != target) check_output("wait_k_timeout", k, target);
  endtask

  task automatic wait_bit(input int bb);
    int n;
    n = 0;
    @(negedge CLK);
    while (!(((63 + k / (2 * DIV)) % 64) == bb && (k % (2 * DIV)) == 1) && n < 2 * FRAME + 8) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2 * FRAME + 8) check_output("wait_bit_timeout", n, 0);
  endtask

  initial begin
    vec_t vecs[10];
    int   load_k;

    vecs[0] = '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
    vecs[1] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[3] = '{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA};
    vecs[4] = '{16'h3C3C, 16'hC3C3, 16'h3C3C, 16'hC3C3};
    vecs[5] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    vecs[6] = '{16'h0000, 16'h0001, 16'h0000, 16'h0001};
    vecs[7] = '{16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF};
    vecs[8] = '{16'h6B2E, 16'h91D4, 16'h6B2E, 16'h91D4};
    vecs[9] = '{16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};

    smp.leftSampleIn  = '0;
    smp.rightSampleIn = '0;
    smp.sampleValid   = 1'b0;
    #2;
    reset_dut("por");

    // Pair accepted before the first load, then one new pair per frame.
    apply_stimulus(16'hA5C3, 16'h8001, 16'hA5C3, 16'h8001);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].l, vecs[i].r, vecs[i].exp_l, vecs[i].exp_r);
    end
    $display("[TB] streamed %0d pairs, starving feed", 11);
    repeat (3 * FRAME) @(negedge CLK);

    // Accept lands on the very edge of a frame load.
    load_k = ((k - 2 * DIV) / FRAME + 1) * FRAME + 2 * DIV;
    wait_k(load_k - 1);
    begin
      acc_t a;
      smp.leftSampleIn  = 16'h0F0F;
      smp.rightSampleIn = 16'hF0F0;
      smp.sampleValid   = 1'b1;
      a.l = 16'h0F0F;
      a.r = 16'hF0F0;
      a.t = $time + HALF;
      acc_q.push_back(a);
    end
    @(negedge CLK);
    smp.sampleValid = 1'b0;
    check_output("coinc_ready", smp.sampleReady, 0);
    check_output("coinc_underrun", underrun, 1);
    repeat (2 * FRAME + 8) @(negedge CLK);

    // Reset mid-frame with a pair waiting in the holding register.
    wait_bit(2);
    apply_stimulus(16'h7777, 16'h3333, 16'h7777, 16'h3333);
    wait_bit(20);
    #2;
    reset_dut("mid");
    wait_k(DIV);
    check_output("first_rise_bclk", BCLK, 1);
    wait_k(2 * DIV);
    check_output("first_fall_bclk", BCLK, 0);
    check_output("first_load_underrun", underrun, 1);
    check_output("first_load_lrclk", LRCLK, 0);
    repeat (2 * FRAME + 8) @(negedge CLK);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
